dmem_access_ctrl: RTL and testbench

//  Sequences and arbitrates the single-port data memory behind the MEM stage. Two requesters share it: the

---
 rtl/dmem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: single-port data memory sequencer arbitrating MEM stage and loader (optional DMEM_ALIGN_CHECK_EN)
module dmem_access_ctrl #(
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_ctl,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic [31:0] pipe_rdata,
  output logic        stall,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);
  typedef enum logic [2:0] {IDLE, PIPE_BUSY, PIPE_DONE, LD_BUSY, LD_DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d, tmo_cnt_q, tmo_cnt_d;
  logic [31:0] pipe_rdata_q, pipe_rdata_d, ld_rdata_q, ld_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        ld_done_q, ld_done_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic        bus_err_q, bus_err_d, align_err_q, align_err_d;
  logic        pipe_req, starve, in_busy, done_now, unused_ok;
  assign pipe_req   = mem_ctl[2] | mem_ctl[1];
  assign starve     = ld_req && wait_cnt_q == 8'(MAX_WAIT);
  assign in_busy    = state_q == PIPE_BUSY || state_q == LD_BUSY;
  assign done_now   = mem_ack || tmo_cnt_q == 8'(TIMEOUT - 1);
  assign unused_ok  = ^{mem_ctl[3], mem_ctl[0], align_err_q};
  assign stall      = pipe_req && state_q != PIPE_DONE;
  assign pipe_rdata = pipe_rdata_q;
  assign ld_rdata   = ld_rdata_q;
  assign ld_done    = ld_done_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign bus_err    = bus_err_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err  = align_err_q;
`endif
  // arbitration, bus sequencing, starvation and timeout bookkeeping
  always_comb begin
    state_d      = state_q;
    pipe_rdata_d = pipe_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    ld_done_d    = 1'b0;
    align_err_d  = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    bus_err_d    = bus_err_q;
    tmo_cnt_d    = in_busy ? tmo_cnt_q + 8'd1 : tmo_cnt_q;
    wait_cnt_d   = (ld_req && state_q != LD_BUSY && state_q != LD_DONE && !starve) ? wait_cnt_q + 8'd1 : wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (starve || (ld_req && !pipe_req)) begin
          state_d     = LD_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = ld_we;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
          wait_cnt_d  = 8'd0;
          tmo_cnt_d   = 8'd0;
        end else if (pipe_req) begin
`ifdef DMEM_ALIGN_CHECK_EN
          if (pipe_addr[1:0] != 2'b00) begin
            state_d      = PIPE_DONE;
            pipe_rdata_d = 32'd0;
            align_err_d  = 1'b1;
          end else
`endif
          begin
            state_d     = PIPE_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = mem_ctl[1];
            mem_addr_d  = pipe_addr;
            mem_wdata_d = pipe_wdata;
            tmo_cnt_d   = 8'd0;
          end
        end
      end
      PIPE_BUSY, LD_BUSY: begin
        if (done_now) begin
          mem_req_d = 1'b0;
          bus_err_d = bus_err_q | ~mem_ack;
          state_d   = state_q == PIPE_BUSY ? PIPE_DONE : LD_DONE;
          ld_done_d = state_q == LD_BUSY;
          ld_rdata_d   = state_q == LD_BUSY ? (mem_ack ? mem_rdata : 32'd0) : ld_rdata_q;
          pipe_rdata_d = (state_q == PIPE_BUSY && !mem_we_q) ? (mem_ack ? mem_rdata : 32'd0) : pipe_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      tmo_cnt_q    <= 8'd0;
      pipe_rdata_q <= 32'd0;
      ld_rdata_q   <= 32'd0;
      ld_done_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      bus_err_q    <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pipe_rdata_q <= pipe_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      ld_done_q    <= ld_done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      bus_err_q    <= bus_err_d;
      align_err_q  <= align_err_d;
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed + randomized checks of dmem_access_ctrl against a memory-image reference model
module tb_dmem_access_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  mem_ctl = 4'd0;
  logic [31:0] pipe_addr = 32'd0, pipe_wdata = 32'd0, pipe_rdata;
  logic        stall, ld_req = 1'b0, ld_we = 1'b0, ld_done;
  logic [31:0] ld_addr = 32'd0, ld_wdata = 32'd0, ld_rdata;
  logic        mem_req, mem_we, mem_ack = 1'b0, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        align_err;
`endif
  int passes = 0, total = 0;
  int lat = 0;
  bit ack_en = 1'b1;
  logic [31:0] dev_mem [64];
  logic [31:0] ref_mem [64];

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_ctl(mem_ctl), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata), .stall(stall), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_done(ld_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
`ifdef DMEM_ALIGN_CHECK_EN
    , .align_err(align_err)
`endif
  );

  always #5 clk = ~clk;

  // memory device: acks after lat extra cycles of mem_req, random data on the bus otherwise
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && ack_en) begin
        if (cnt == lat) begin
          mem_ack = 1'b1;
          if (mem_we) dev_mem[mem_addr[7:2]] = mem_wdata;
          mem_rdata = mem_we ? $urandom : dev_mem[mem_addr[7:2]];
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic pipe_op(input bit we, input logic [31:0] a, input logic [31:0] wd, input int l, input bit tmo);
    int nst, nreq, bad;
    logic [31:0] prev, exp;
    logic [3:0] r;
    nst = 0; nreq = 0; bad = 0;
    prev = pipe_rdata;
    r = 4'($urandom);
    lat = l;
    mem_ctl = we ? {r[3], r[2], 1'b1, r[0]} : {r[3], 1'b1, 1'b0, r[0]};
    pipe_addr = a;
    pipe_wdata = wd;
    #1;
    while (stall && nst < 100) begin
      nst++;
      if (mem_req) begin
        nreq++;
        if (mem_we !== we || mem_addr !== a || (we && mem_wdata !== wd)) bad++;
      end
      tick();
    end
    exp = we ? prev : (tmo ? 32'd0 : ref_mem[a[7:2]]);
    chk("pipe_stall_cycles", nst, l + 2);
    chk("pipe_req_cycles", nreq, l + 1);
    chk("pipe_bus_stable", bad, 0);
    chk("pipe_rdata", pipe_rdata, exp);
    if (we && !tmo) ref_mem[a[7:2]] = wd;
    mem_ctl = 4'd0;
    pipe_addr = $urandom;
    tick();
  endtask

  task automatic ld_op(input bit we, input logic [31:0] a, input logic [31:0] wd, input int l);
    int n, nreq, bad;
    n = 0; nreq = 0; bad = 0;
    lat = l;
    ld_req = 1'b1;
    ld_we = we;
    ld_addr = a;
    ld_wdata = wd;
    #1;
    while (!ld_done && n < 100) begin
      if (mem_req) begin
        nreq++;
        if (mem_we !== we || mem_addr !== a || (we && mem_wdata !== wd)) bad++;
      end
      if (stall) bad++;
      tick();
      n++;
    end
    chk("ld_latency", n, l + 2);
    chk("ld_req_cycles", nreq, l + 1);
    chk("ld_bus_stable", bad, 0);
    if (!we) chk("ld_rdata", ld_rdata, ref_mem[a[7:2]]);
    if (we) ref_mem[a[7:2]] = wd;
    ld_req = 1'b0;
    tick();
    chk("ld_done_pulse", {31'd0, ld_done}, 0);
  endtask

  initial begin
    int n, nreq, npipe;
    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[4] = 32'hCAFEF00D;
    ref_mem[4] = 32'hCAFEF00D;
    repeat (3) tick();
    chk("rst_pipe_rdata", pipe_rdata, 0);
    chk("rst_ld_rdata", ld_rdata, 0);
    chk("rst_ld_done", {31'd0, ld_done}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_bus_err", {31'd0, bus_err}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    rst = 1'b0;
    tick();
    // pipeline load with immediate ack, then a store with 3 cycles of ack delay
    pipe_op(1'b0, 32'h10, 32'h0, 0, 1'b0);
    chk("load_cafe", pipe_rdata, 32'hCAFEF00D);
    pipe_op(1'b1, 32'h20, 32'h12345678, 3, 1'b0);
    ld_op(1'b0, 32'h20, 32'h0, 1);
    chk("store_readback", ld_rdata, 32'h12345678);
    // contention: pipeline keeps loading, loader waits until starved
    lat = 0;
    mem_ctl = 4'b0100;
    pipe_addr = 32'h40;
    ld_req = 1'b1;
    ld_we = 1'b0;
    ld_addr = 32'h44;
    #1;
    n = 0; npipe = 0;
    while (!ld_done && n < 200) begin
      if (mem_req && mem_addr == 32'h40) npipe++;
      tick();
      n++;
    end
    chk("starve_pipe_grants", npipe, (8 + 2) / 3);
    chk("starve_stall_held", {31'd0, stall}, 1);
    chk("starve_ld_rdata", ld_rdata, ref_mem[17]);
    ld_req = 1'b0;
    tick();
    chk("starve_ld_done_pulse", {31'd0, ld_done}, 0);
    n = 0;
    while (stall && n < 20) begin
      tick();
      n++;
    end
    chk("pipe_after_ld_cycles", n, 2);
    chk("pipe_after_ld_rdata", pipe_rdata, ref_mem[16]);
    mem_ctl = 4'd0;
    tick();
    // timeout on a pipeline load, bus_err stays set afterwards
    ack_en = 1'b0;
    pipe_op(1'b0, 32'h30, 32'h0, 15, 1'b1);
    chk("tmo_bus_err", {31'd0, bus_err}, 1);
    ack_en = 1'b1;
    pipe_op(1'b0, 32'h10, 32'h0, 0, 1'b0);
    chk("tmo_bus_err_sticky", {31'd0, bus_err}, 1);
    // reset while the pipeline is waiting for an ack, then a stray ack
    lat = 5;
    mem_ctl = 4'b0100;
    pipe_addr = 32'h10;
    #1;
    tick();
    chk("rst_mid_req_before", {31'd0, mem_req}, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_req", {31'd0, mem_req}, 0);
    chk("rst_mid_bus_err", {31'd0, bus_err}, 0);
    chk("rst_mid_pipe_rdata", pipe_rdata, 0);
    chk("rst_mid_addr", mem_addr, 0);
    rst = 1'b0;
    mem_ctl = 4'd0;
    ack_en = 1'b0;
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    chk("stray_ack_req", {31'd0, mem_req}, 0);
    chk("stray_ack_ld_done", {31'd0, ld_done}, 0);
    chk("stray_ack_pipe_rdata", pipe_rdata, 0);
    chk("stray_ack_stall", {31'd0, stall}, 0);
    ack_en = 1'b1;
    tick();
    pipe_op(1'b0, 32'h10, 32'h0, 0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    // misaligned pipeline load never reaches the bus
    mem_ctl = 4'b0100;
    pipe_addr = 32'h13;
    #1;
    n = 0; nreq = 0;
    while (stall && n < 20) begin
      if (mem_req) nreq++;
      tick();
      n++;
    end
    chk("align_stall_cycles", n, 1);
    chk("align_no_req", nreq, 0);
    chk("align_err_pulse", {31'd0, align_err}, 1);
    chk("align_rdata", pipe_rdata, 0);
    mem_ctl = 4'd0;
    tick();
    chk("align_err_clear", {31'd0, align_err}, 0);
`endif
    // randomized mix of pipeline and loader traffic
    repeat (40) begin
      logic [31:0] a, wd;
      bit we;
      int l;
      a = 32'h80 + 32'(4 * $urandom_range(0, 7));
      wd = $urandom;
      we = 1'($urandom);
      l = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) pipe_op(we, a, wd, l, 1'b0);
      else ld_op(we, a, wd, l);
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
